// File: rtl/alu_share_if.sv
// alu_share_if: request, shared-ALU and response signals of the ALU share scheduler
// master: requester/response-consumer/ALU side; slave: the scheduler
interface alu_share_if #(parameter int DATA_W = 32);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [11:0] req_op;
  logic [11:0] req_func;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [3:0] alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic rsp_valid;
  logic rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_err;
  logic rsp_ready;
  modport master (
    output req_valid, req_op, req_func, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport slave (
    input  req_valid, req_op, req_func, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_share_scheduler.sv
// alu_share_scheduler: round-robin arbiter and MIPS decoder sharing one ALU between two requesters
// clk, rst_n (async active-low); bus: req_* two-requester inputs with one-hot req_ready,
// alu_* operands/control out and alu_result in, rsp_* single response channel
module alu_share_scheduler #(
  parameter int DATA_W = 32,
  parameter int ALU_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  alu_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic rr, gid, xfer, done, id_q, err_q;
  logic [1:0] gnt;
  logic [5:0] sel_op, sel_func;
  logic [3:0] code, ctrl_q;
  logic [2:0] cnt;
  logic [DATA_W-1:0] a_q, b_q, data_q;
  function automatic logic [3:0] decode(input logic [5:0] o, input logic [5:0] f);
    logic [3:0] d;
    d = 4'b1111;
    if (o == 6'b000000)
      case (f)
        6'b100000: d = 4'b0000;
        6'b100010: d = 4'b0001;
        6'b100100: d = 4'b0010;
        6'b100101: d = 4'b0011;
        6'b100110: d = 4'b0101;
        6'b100111: d = 4'b0110;
        6'b000000: d = 4'b0111;
        6'b000011: d = 4'b1000;
        6'b000010: d = 4'b1001;
        6'b101010: d = 4'b1100;
        default:   d = 4'b1111;
      endcase
    else
      case (o)
        6'b001000, 6'b100011, 6'b101011: d = 4'b0000;
        6'b000100: d = 4'b0001;
        6'b001100: d = 4'b0010;
        6'b001101: d = 4'b0011;
        6'b001110: d = 4'b0101;
        6'b001010: d = 4'b1100;
        default:   d = 4'b1111;
      endcase
    return d;
  endfunction
  // Grant is gated by rst_n so req_ready reads 00 while reset is held.
  always_comb begin
    gnt = bus.req_valid == 2'b11 ? (rr ? 2'b10 : 2'b01) : bus.req_valid;
    bus.req_ready = (state == IDLE && rst_n) ? gnt : 2'b00;
    xfer = |bus.req_ready;
    gid = bus.req_ready[1];
    sel_op = gid ? bus.req_op[11:6] : bus.req_op[5:0];
    sel_func = gid ? bus.req_func[11:6] : bus.req_func[5:0];
    code = decode(sel_op, sel_func);
    done = state == EXEC && cnt == 3'(ALU_LAT);
  end
  always_comb begin
    state_nx = state == IDLE ? (xfer ? (code == 4'b1111 ? RESP : EXEC) : IDLE) :
               state == EXEC ? (done ? RESP : EXEC) :
               state == RESP ? (bus.rsp_ready ? IDLE : RESP) : IDLE;
    bus.alu_ctrl = state == IDLE ? 4'b1111 : ctrl_q;
    bus.alu_a = state == IDLE ? '0 : a_q;
    bus.alu_b = state == IDLE ? '0 : b_q;
    bus.rsp_valid = state == RESP;
    bus.rsp_id = id_q;
    bus.rsp_data = data_q;
    bus.rsp_err = err_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // data_q is cleared on accept so an unsupported op responds with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
      cnt <= 3'd0;
      ctrl_q <= 4'b1111;
      a_q <= '0;
      b_q <= '0;
      id_q <= 1'b0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (xfer) begin
        rr <= ~gid;
        ctrl_q <= code;
        a_q <= gid ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
        b_q <= gid ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
        id_q <= gid;
        err_q <= code == 4'b1111;
        data_q <= '0;
        cnt <= code == 4'b1111 ? 3'd0 : 3'd1;
      end
      if (state == EXEC) cnt <= done ? 3'd0 : cnt + 3'd1;
      if (done) data_q <= bus.alu_result;
    end
  end
endmodule

// File: tb/tb_alu_share_scheduler.sv
// tb_alu_share_scheduler: directed checks of arbitration, decode, latency, backpressure and reset
module tb_alu_share_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  alu_share_if #(.DATA_W(32)) b1 ();
  alu_share_if #(.DATA_W(32)) b3 ();
  alu_share_scheduler #(.DATA_W(32), .ALU_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  alu_share_scheduler #(.DATA_W(32), .ALU_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    return c == 4'h0 ? a + b : c == 4'h1 ? a - b : 32'h0;
  endfunction
  assign b1.alu_result = alu_model(b1.alu_ctrl, b1.alu_a, b1.alu_b);
  assign b3.alu_result = alu_model(b3.alu_ctrl, b3.alu_a, b3.alu_b);
  logic [5:0] t_op [20] = '{6'b001000, 6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000000, 6'b001100,
                            6'b000000, 6'b001101, 6'b000000, 6'b001110, 6'b000000, 6'b000000, 6'b000000,
                            6'b000000, 6'b000000, 6'b001010, 6'b000000, 6'b000000, 6'b111111};
  logic [5:0] t_fn [20] = '{6'b100010, 6'b100010, 6'b100010, 6'b100000, 6'b100000, 6'b100010, 6'b100010,
                            6'b100100, 6'b100010, 6'b100101, 6'b100010, 6'b100110, 6'b100111, 6'b000000,
                            6'b000011, 6'b000010, 6'b100010, 6'b101010, 6'b100001, 6'b100000};
  logic [3:0] t_ex [20] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3,
                            4'h5, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hC, 4'hF, 4'hF};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int i, input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    b1.req_op[i*6 +: 6] = op;
    b1.req_func[i*6 +: 6] = fn;
    b1.req_a[i*32 +: 32] = a;
    b1.req_b[i*32 +: 32] = b;
  endtask
  task automatic test_reset();
    #2;
    b1.req_valid = 2'b11;
    #1;
    n_chk++; if (b1.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready got %b want 00", b1.req_ready); end
    n_chk++; if (b1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 0", b1.rsp_valid); end
    n_chk++; if (b1.rsp_id !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_id got %b want 0", b1.rsp_id); end
    n_chk++; if (b1.rsp_data !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_data got %0d want 0", b1.rsp_data); end
    n_chk++; if (b1.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got %b want 0", b1.rsp_err); end
    n_chk++; if (b1.alu_ctrl !== 4'b1111) begin n_fail++; $display("FAIL rst_alu_ctrl got %b want 1111", b1.alu_ctrl); end
    n_chk++; if ({b1.alu_a, b1.alu_b} !== 64'd0) begin n_fail++; $display("FAIL rst_alu_ab got %h want 0", {b1.alu_a, b1.alu_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (b1.req_ready !== 2'b01) begin n_fail++; $display("FAIL first_grant got %b want 01", b1.req_ready); end
    b1.req_valid = 2'b00;
  endtask
  task automatic test_back_to_back();
    int g, got;
    g = 0;
    got = 0;
    drive(0, 6'b000000, 6'b100000, 32'd1, 32'd2);
    drive(1, 6'b000000, 6'b100000, 32'd10, 32'd20);
    b1.rsp_ready = 1'b1;
    b1.req_valid = 2'b11;
    #1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (b1.req_ready !== 2'b00) begin
        n_chk++; if (b1.req_ready !== (g[0] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", g, b1.req_ready, g[0] ? 2'b10 : 2'b01); end
        g++;
      end
      step();
      if (b1.rsp_valid === 1'b1) begin
        n_chk++; if (b1.rsp_id !== got[0]) begin n_fail++; $display("FAIL rr_rsp_id%0d got %b want %b", got, b1.rsp_id, got[0]); end
        n_chk++; if (b1.rsp_data !== (got[0] ? 32'd30 : 32'd3)) begin n_fail++; $display("FAIL rr_rsp_data%0d got %0d want %0d", got, b1.rsp_data, got[0] ? 30 : 3); end
        got++;
      end
    end
    b1.req_valid = 2'b00;
    n_chk++; if (got != 4 || g != 4) begin n_fail++; $display("FAIL rr_count got %0d rsp %0d grants want 4 4", got, g); end
    step();
  endtask
  task automatic test_basic();
    drive(0, 6'b000000, 6'b100000, 32'd5, 32'd7);
    b1.rsp_ready = 1'b0;
    b1.req_valid = 2'b01;
    #1;
    n_chk++; if (b1.req_ready !== 2'b01) begin n_fail++; $display("FAIL basic_ready got %b want 01", b1.req_ready); end
    step();
    b1.req_valid = 2'b00;
    n_chk++; if (b1.alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL basic_ctrl got %b want 0000", b1.alu_ctrl); end
    n_chk++; if (b1.alu_a !== 32'd5 || b1.alu_b !== 32'd7) begin n_fail++; $display("FAIL basic_ops got %0d %0d want 5 7", b1.alu_a, b1.alu_b); end
    n_chk++; if (b1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", b1.rsp_valid); end
    step();
    n_chk++; if (b1.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", b1.rsp_valid); end
    n_chk++; if (b1.rsp_id !== 1'b0) begin n_fail++; $display("FAIL basic_id got %b want 0", b1.rsp_id); end
    n_chk++; if (b1.rsp_data !== 32'd12) begin n_fail++; $display("FAIL basic_data got %0d want 12", b1.rsp_data); end
    n_chk++; if (b1.rsp_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", b1.rsp_err); end
    b1.rsp_ready = 1'b1;
    step();
    n_chk++; if (b1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop got %b want 0", b1.rsp_valid); end
    n_chk++; if (b1.alu_ctrl !== 4'b1111) begin n_fail++; $display("FAIL basic_idle_ctrl got %b want 1111", b1.alu_ctrl); end
  endtask
  task automatic test_unsupported();
    drive(1, 6'b111111, 6'b000000, 32'd3, 32'd4);
    b1.rsp_ready = 1'b0;
    b1.req_valid = 2'b10;
    #1;
    n_chk++; if (b1.req_ready !== 2'b10) begin n_fail++; $display("FAIL unsup_ready got %b want 10", b1.req_ready); end
    step();
    b1.req_valid = 2'b00;
    n_chk++; if (b1.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL unsup_valid got %b want 1", b1.rsp_valid); end
    n_chk++; if (b1.rsp_err !== 1'b1) begin n_fail++; $display("FAIL unsup_err got %b want 1", b1.rsp_err); end
    n_chk++; if (b1.rsp_data !== 32'd0) begin n_fail++; $display("FAIL unsup_data got %0d want 0", b1.rsp_data); end
    n_chk++; if (b1.rsp_id !== 1'b1) begin n_fail++; $display("FAIL unsup_id got %b want 1", b1.rsp_id); end
    n_chk++; if (b1.alu_ctrl !== 4'b1111) begin n_fail++; $display("FAIL unsup_ctrl got %b want 1111", b1.alu_ctrl); end
    b1.rsp_ready = 1'b1;
    step();
    n_chk++; if (b1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL unsup_drop got %b want 0", b1.rsp_valid); end
  endtask
  task automatic test_backpressure();
    drive(0, 6'b000100, 6'b000000, 32'd20, 32'd8);
    b1.rsp_ready = 1'b0;
    b1.req_valid = 2'b01;
    #1;
    step();
    n_chk++; if (b1.alu_ctrl !== 4'b0001) begin n_fail++; $display("FAIL bp_ctrl got %b want 0001", b1.alu_ctrl); end
    b1.req_valid = 2'b11;
    step();
    n_chk++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 32'd12) begin n_fail++; $display("FAIL bp_first got valid %b data %0d want 1 12", b1.rsp_valid, b1.rsp_data); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++; if ({b1.rsp_valid, b1.rsp_id, b1.rsp_err} !== 3'b100) begin n_fail++; $display("FAIL bp_hold%0d got v/id/err %b want 100", k, {b1.rsp_valid, b1.rsp_id, b1.rsp_err}); end
      n_chk++; if (b1.rsp_data !== 32'd12) begin n_fail++; $display("FAIL bp_data%0d got %0d want 12", k, b1.rsp_data); end
      n_chk++; if (b1.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready%0d got %b want 00", k, b1.req_ready); end
    end
    b1.rsp_ready = 1'b1;
    #1;
    n_chk++; if (b1.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_resp_accept got %b want 00", b1.req_ready); end
    step();
    n_chk++; if (b1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got %b want 0", b1.rsp_valid); end
    n_chk++; if (b1.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_idle_grant got %b want 10", b1.req_ready); end
    b1.req_valid = 2'b00;
  endtask
  task automatic test_decode();
    b1.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(0, t_op[i], t_fn[i], 32'd0, 32'd0);
      b1.req_valid = 2'b01;
      step();
      b1.req_valid = 2'b00;
      n_chk++; if (b1.alu_ctrl !== t_ex[i]) begin n_fail++; $display("FAIL decode%0d op %b fn %b got %b want %b", i, t_op[i], t_fn[i], b1.alu_ctrl, t_ex[i]); end
      for (int c = 0; c < 8 && b1.rsp_valid !== 1'b1; c++) step();
      n_chk++; if ({b1.rsp_valid, b1.rsp_err} !== {1'b1, t_ex[i] == 4'hF}) begin n_fail++; $display("FAIL decode_err%0d got v/err %b want 1%b", i, {b1.rsp_valid, b1.rsp_err}, t_ex[i] == 4'hF); end
      step();
    end
  endtask
  task automatic test_reset_exec();
    int seen;
    seen = 0;
    b3.req_op = 12'd0;
    b3.req_func = {6'b000000, 6'b100000};
    b3.req_a = {32'd0, 32'd1};
    b3.req_b = {32'd0, 32'd2};
    b3.rsp_ready = 1'b1;
    b3.req_valid = 2'b01;
    step();
    b3.req_valid = 2'b00;
    n_chk++; if (b3.alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL rex_ctrl got %b want 0000", b3.alu_ctrl); end
    step();
    n_chk++; if (b3.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rex_early got %b want 0", b3.rsp_valid); end
    b3.req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (b3.alu_ctrl !== 4'b1111) begin n_fail++; $display("FAIL rex_alu_ctrl got %b want 1111", b3.alu_ctrl); end
    n_chk++; if ({b3.alu_a, b3.alu_b} !== 64'd0) begin n_fail++; $display("FAIL rex_alu_ab got %h want 0", {b3.alu_a, b3.alu_b}); end
    n_chk++; if ({b3.rsp_valid, b3.rsp_id, b3.rsp_err, b3.req_ready} !== 5'd0) begin n_fail++; $display("FAIL rex_ctl got %b want 00000", {b3.rsp_valid, b3.rsp_id, b3.rsp_err, b3.req_ready}); end
    n_chk++; if (b3.rsp_data !== 32'd0) begin n_fail++; $display("FAIL rex_data got %0d want 0", b3.rsp_data); end
    b3.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (b3.rsp_valid === 1'b1) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rex_no_rsp got %0d cycles want 0", seen); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    b1.req_valid = 2'b00;
    b1.req_op = '0;
    b1.req_func = '0;
    b1.req_a = '0;
    b1.req_b = '0;
    b1.rsp_ready = 1'b0;
    b3.req_valid = 2'b00;
    b3.req_op = '0;
    b3.req_func = '0;
    b3.req_a = '0;
    b3.req_b = '0;
    b3.rsp_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_basic();
    test_unsupported();
    test_backpressure();
    test_decode();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
